// File: rtl/out_port_uart_tx_pkg.sv
// rtl/out_port_uart_tx_pkg.sv - shared FSM state type and frame/buffer constants for the OUT-port UART transmitter
package out_port_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_t;

  localparam int FRAME_BITS      = 10;
  localparam int BYTE_FIFO_DEPTH = 4;

endpackage

// File: rtl/out_port_uart_tx_byte_fifo.sv
// rtl/out_port_uart_tx_byte_fifo.sv - 4-entry byte FIFO with 2-bit wrapping pointers; push and pop may coincide even when full
module byte_fifo
  import out_port_uart_tx_pkg::*;
#(
  parameter int DEPTH = BYTE_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wrData,
  output logic [7:0] rdData,
  output logic [2:0] count,
  output logic       full,
  output logic       empty
);

  logic [7:0] mem [DEPTH];
  logic [1:0] wrPtr;
  logic [1:0] rdPtr;
  logic       pushOk;
  logic       popOk;

  // A pop in the same cycle frees the slot the push lands in, so a full FIFO still accepts.
  assign pushOk = push && (!full || pop);
  assign popOk  = pop && !empty;
  assign full   = (count == 3'(DEPTH));
  assign empty  = (count == 3'd0);
  assign rdData = mem[rdPtr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= 2'd0;
      rdPtr <= 2'd0;
      count <= 3'd0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + 2'd1;
      if (popOk)  rdPtr <= rdPtr + 2'd1;
      count <= count + {2'b00, pushOk} - {2'b00, popOk};
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/out_port_uart_tx.sv
// rtl/out_port_uart_tx.sv - buffered 8N1 serial transmitter fed from the processor OUT register
module out_port_uart_tx
  import out_port_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = BYTE_FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_we,
  input  logic       ovf_clr,
  output logic       tx,
  output logic       busy,
  output logic [2:0] fifo_count,
  output logic       overflow
);

  localparam logic [7:0] BIT_LOAD = 8'(CLKS_PER_BIT - 1);

  txState_t   state;
  txState_t   stateNext;
  logic [7:0] timer;
  logic [7:0] timerNext;
  logic [2:0] bitIdx;
  logic [2:0] bitIdxNext;
  logic [7:0] shift;
  logic [7:0] shiftNext;
  logic       txNext;
  logic       pop;
  logic       fifoFull;
  logic       fifoEmpty;
  logic [7:0] headByte;
  logic       ovfEvent;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
    .clk    (clk),
    .reset  (reset),
    .push   (data_we),
    .pop    (pop),
    .wrData (data_in),
    .rdData (headByte),
    .count  (fifo_count),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  assign busy     = (state != IDLE);
  assign ovfEvent = data_we && fifoFull && !pop;

  // txNext is the line level for the state being entered, so tx leaves a flop.
  always_comb begin
    stateNext  = state;
    timerNext  = timer;
    bitIdxNext = bitIdx;
    shiftNext  = shift;
    txNext     = tx;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        txNext = 1'b1;
        if (!fifoEmpty) begin
          pop       = 1'b1;
          shiftNext = headByte;
          timerNext = BIT_LOAD;
          txNext    = 1'b0;
          stateNext = START;
        end
      end
      START: begin
        if (timer == 8'd0) begin
          stateNext  = DATA;
          timerNext  = BIT_LOAD;
          bitIdxNext = 3'd0;
          txNext     = shift[0];
        end else begin
          timerNext = timer - 8'd1;
        end
      end
      DATA: begin
        if (timer == 8'd0) begin
          timerNext = BIT_LOAD;
          if (bitIdx == 3'd7) begin
            stateNext = STOP;
            txNext    = 1'b1;
          end else begin
            bitIdxNext = bitIdx + 3'd1;
            shiftNext  = {1'b0, shift[7:1]};
            txNext     = shift[1];
          end
        end else begin
          timerNext = timer - 8'd1;
        end
      end
      STOP: begin
        if (timer == 8'd0) begin
          stateNext = IDLE;
          txNext    = 1'b1;
        end else begin
          timerNext = timer - 8'd1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      timer    <= 8'd0;
      bitIdx   <= 3'd0;
      shift    <= 8'd0;
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state  <= stateNext;
      timer  <= timerNext;
      bitIdx <= bitIdxNext;
      shift  <= shiftNext;
      tx     <= txNext;
      if (ovfEvent)     overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: doc/out_port_uart_tx.md
OUT_PORT_UART_TX -- requirements
Module: out_port_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 2..255.
REQ-002 Parameter FIFO_DEPTH, default 4: byte buffer depth; fixed at 4 in this revision.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 data_in  input  8  byte from the processor OUT register.
REQ-006 data_we  input  1  one-cycle write strobe; top level drives it from the WEinOut control line.
REQ-007 ovf_clr  input  1  synchronous clear of the overflow flag.
REQ-008 tx  output  1  serial line, 8N1, LSB first, idle high.
REQ-009 busy  output  1  high while a frame (start, data or stop bit) is on tx.
REQ-010 fifo_count  output  3  number of bytes held in the buffer, 0..4.
REQ-011 overflow  output  1  sticky flag: a write was dropped.

Function
REQ-012 Buffer shall be a 4-entry FIFO; a data_we with fifo_count<4 shall store data_in, visible in fifo_count next cycle.
REQ-013 A data_we with fifo_count==4 and no pop in the same cycle shall drop the byte and set overflow next cycle.
REQ-014 A data_we and a pop in the same cycle shall both take effect, including when full; fifo_count shall be unchanged and overflow shall not set.
REQ-015 Read/write pointers shall be 2 bits and wrap 3->0; fifo_count shall never exceed 4 or go below 0.
REQ-016 FSM states shall be IDLE, START, DATA and STOP.
REQ-017 IDLE: when fifo_count>0, pop the head byte into the shift register and enter START next cycle; otherwise stay in IDLE.
REQ-018 START: tx=0 for CLKS_PER_BIT cycles, then enter DATA.
REQ-019 DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit; after bit index 7, enter STOP.
REQ-020 STOP: tx=1 for CLKS_PER_BIT cycles, then enter IDLE.
REQ-021 The bit timer shall load CLKS_PER_BIT-1 on each state or bit entry and count down to 0.
REQ-022 The 3-bit bit index shall count 0..7 and reset to 0 on entry to DATA.
REQ-023 Latency: data_we in cycle N into an empty FIFO in IDLE shall give the first tx=0 in cycle N+2.
REQ-024 A frame shall be exactly 10*CLKS_PER_BIT cycles of tx.
REQ-025 Between back-to-back frames, tx shall stay high for exactly 1 IDLE cycle.
REQ-026 busy shall be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-027 tx shall be driven from a register, with no combinational path from inputs.
REQ-028 ovf_clr shall clear overflow next cycle; if ovf_clr and an overflow event occur in the same cycle, overflow shall be set.
REQ-029 data_we while busy shall only affect the FIFO, never the frame in progress.

Reset
REQ-030 While reset=0: tx=1, busy=0, fifo_count=0, overflow=0, FSM=IDLE, pointers, timer and bit index all 0.
REQ-031 Assertion mid-frame shall abort the frame immediately (tx=1 asynchronously) and discard all buffered bytes.
REQ-032 The first data_we shall be honoured on the first rising edge after reset deasserts.

Structure
REQ-033 A shared package shall hold the FSM state enum, the frame-length constant (10) and the FIFO depth constant.
REQ-034 The FIFO shall be a sub-module named byte_fifo, with push, pop, data, count and full/empty ports; the FSM and serializer stay in out_port_uart_tx.

Verification
REQ-035 Reset, then data_we with data_in=0xA5, CLKS_PER_BIT=4 -> tx=0 from cycle N+2; bits 1,0,1,0,0,1,0,1 at 4 cycles each; stop=1; busy high for 40 cycles.
REQ-036 5 writes 0x01..0x05 in consecutive cycles while idle -> 0x01 popped at once; 0x02..0x05 buffered; all 5 frames sent in order; overflow=0.
REQ-037 6 writes in consecutive cycles -> the 6th is dropped, overflow=1 and stays 1 until ovf_clr; 5 frames sent.
REQ-038 Write while full in the same cycle as an IDLE pop -> byte accepted, fifo_count stays 4, overflow=0.
REQ-039 reset=0 asserted mid DATA bit 3 with 2 bytes buffered -> tx=1 immediately, fifo_count=0, busy=0; no frame after release.
REQ-040 Back-to-back frames -> exactly 1 high IDLE cycle between a stop bit and the next start bit.
